// File: rtl/rf_wport_arbiter_if.sv
// Bundle of WB, MDU, issue-stage and regfile-write signals around the write-port arbiter.
interface rf_wport_arbiter_if #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 32
);
  logic              pipe_wen_i;
  logic [4:0]        pipe_idx_i;
  logic [XLEN-1:0]   pipe_wdata_i;
  logic              pipe_ready_o;

  logic              mdu_issue_i;
  logic [4:0]        mdu_issue_rd_i;
  logic              mdu_valid_i;
  logic [4:0]        mdu_idx_i;
  logic [XLEN-1:0]   mdu_wdata_i;
  logic              mdu_ready_o;

  logic [4:0]        id_rs1_idx_i;
  logic [4:0]        id_rs2_idx_i;
  logic              id_rd_wen_i;
  logic [4:0]        id_rd_idx_i;
  logic              hazard_o;

  logic              rd_wen_o;
  logic [4:0]        rd_idx_o;
  logic [XLEN-1:0]   rd_wdata_o;

  logic [CNT_W-1:0]  arb_conflict_cnt_o;

  // Upstream/environment side: drives requests, observes grants and hazards.
  modport master (
    output pipe_wen_i, pipe_idx_i, pipe_wdata_i,
    output mdu_issue_i, mdu_issue_rd_i, mdu_valid_i, mdu_idx_i, mdu_wdata_i,
    output id_rs1_idx_i, id_rs2_idx_i, id_rd_wen_i, id_rd_idx_i,
    input  pipe_ready_o, mdu_ready_o, hazard_o,
    input  rd_wen_o, rd_idx_o, rd_wdata_o, arb_conflict_cnt_o
  );

  // Arbiter side.
  modport slave (
    input  pipe_wen_i, pipe_idx_i, pipe_wdata_i,
    input  mdu_issue_i, mdu_issue_rd_i, mdu_valid_i, mdu_idx_i, mdu_wdata_i,
    input  id_rs1_idx_i, id_rs2_idx_i, id_rd_wen_i, id_rd_idx_i,
    output pipe_ready_o, mdu_ready_o, hazard_o,
    output rd_wen_o, rd_idx_o, rd_wdata_o, arb_conflict_cnt_o
  );
endinterface

// File: rtl/rf_wport_arbiter.sv
// Regfile write-port arbiter: pipeline WB vs. one buffered MDU result, with starvation guard
// and MDU pending-destination scoreboard. Define RF_ARB_STATS_EN to enable the conflict counter.
module rf_wport_arbiter #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CNT_W      = 32
) (
  input logic              clk,
  input logic              rst_n,
  rf_wport_arbiter_if.slave bus
);

  localparam int unsigned NREG  = 32;
  localparam int unsigned IDX_W = 5;
  localparam int unsigned SC_W  = $clog2(STARVE_MAX + 1);

  logic              buf_vld_q,  buf_vld_d;
  logic [IDX_W-1:0]  buf_idx_q,  buf_idx_d;
  logic [XLEN-1:0]   buf_data_q, buf_data_d;
  logic [SC_W-1:0]   starve_q,   starve_d;
  logic [NREG-1:0]   busy_q,     busy_d;

  logic              pipe_req_c;
  logic              force_c;
  logic              buf_gnt_c;
  logic              pipe_gnt_c;
  logic              accept_c;
  logic [NREG-1:0]   set_mask_c;
  logic [NREG-1:0]   clr_mask_c;
  logic [NREG-1:0]   live_busy_c;

  // Request decode and same-cycle arbitration.
  always_comb begin
    pipe_req_c = bus.pipe_wen_i && (bus.pipe_idx_i != '0);
    force_c    = buf_vld_q && (starve_q == SC_W'(STARVE_MAX));
    buf_gnt_c  = buf_vld_q && (force_c || !pipe_req_c);
    pipe_gnt_c = pipe_req_c && !buf_gnt_c;
    accept_c   = bus.mdu_valid_i && !buf_vld_q;
  end

  // Regfile write mux and handshake outputs.
  always_comb begin
    bus.rd_wen_o     = 1'b0;
    bus.rd_idx_o     = '0;
    bus.rd_wdata_o   = '0;
    if (buf_gnt_c) begin
      bus.rd_wen_o   = 1'b1;
      bus.rd_idx_o   = buf_idx_q;
      bus.rd_wdata_o = buf_data_q;
    end else if (pipe_gnt_c) begin
      bus.rd_wen_o   = 1'b1;
      bus.rd_idx_o   = bus.pipe_idx_i;
      bus.rd_wdata_o = bus.pipe_wdata_i;
    end
    bus.pipe_ready_o = !force_c;
    bus.mdu_ready_o  = !buf_vld_q;
  end

  // Result buffer and starvation counter next state.
  always_comb begin
    buf_vld_d  = buf_vld_q;
    buf_idx_d  = buf_idx_q;
    buf_data_d = buf_data_q;
    starve_d   = starve_q;
    if (accept_c) begin
      buf_vld_d  = 1'b1;
      buf_idx_d  = bus.mdu_idx_i;
      buf_data_d = bus.mdu_wdata_i;
    end else if (buf_gnt_c) begin
      buf_vld_d  = 1'b0;
    end
    if (!buf_vld_q || buf_gnt_c) begin
      starve_d = '0;
    end else if (starve_q != SC_W'(STARVE_MAX)) begin
      starve_d = starve_q + SC_W'(1);
    end
  end

  // Scoreboard: a buffer grant retires its destination in the same cycle for hazard purposes;
  // a concurrent re-issue to that register keeps it busy.
  always_comb begin
    set_mask_c  = '0;
    clr_mask_c  = '0;
    if (bus.mdu_issue_i && (bus.mdu_issue_rd_i != '0)) begin
      set_mask_c = NREG'(1) << bus.mdu_issue_rd_i;
    end
    if (buf_gnt_c) begin
      clr_mask_c = NREG'(1) << buf_idx_q;
    end
    live_busy_c = busy_q & ~clr_mask_c;
    busy_d      = live_busy_c | set_mask_c;
    busy_d[0]   = 1'b0;
    bus.hazard_o = live_busy_c[bus.id_rs1_idx_i] ||
                   live_busy_c[bus.id_rs2_idx_i] ||
                   (bus.id_rd_wen_i && live_busy_c[bus.id_rd_idx_i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_vld_q  <= 1'b0;
      buf_idx_q  <= '0;
      buf_data_q <= '0;
      starve_q   <= '0;
      busy_q     <= '0;
    end else begin
      buf_vld_q  <= buf_vld_d;
      buf_idx_q  <= buf_idx_d;
      buf_data_q <= buf_data_d;
      starve_q   <= starve_d;
      busy_q     <= busy_d;
    end
  end

`ifdef RF_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Cycles where both sources want the port; wraps naturally.
  always_comb begin
    cnt_d = cnt_q;
    if (pipe_req_c && buf_vld_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.arb_conflict_cnt_o = cnt_q;
`else
  assign bus.arb_conflict_cnt_o = CNT_W'(0);
`endif

`ifndef SYNTHESIS
  // Issuing to a destination that is still pending is an issue-stage bug.
  a_issue_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.mdu_issue_i && (bus.mdu_issue_rd_i != '0) && live_busy_c[bus.mdu_issue_rd_i]))
    else $error("rf_wport_arbiter: MDU issue to busy rd %0d", bus.mdu_issue_rd_i);
`endif

endmodule
